// File: rtl/gobang_move_sequencer.sv
// Move sequencer for the gobang board: handshake, legality check, board update,
// serial four-direction win scan, result reporting. Optional overline rule: GOBANG_EXACT_FIVE_EN.
//
// state  | meaning
// IDLE   | waiting for a move (ready when game not over)
// CHECK  | bounds/occupancy check, stone placement
// SCAN   | one cell per cycle along d0..d3, forward then backward
// RESULT | publish result, update turn / winner / game_over
module gobang_move_sequencer #(
   parameter int BOARD_N = 15,
   parameter int WIN_LEN = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         new_game,
   input  logic                         move_valid,
   output logic                         move_ready,
   input  logic [3:0]                   move_row,
   input  logic [3:0]                   move_col,
   output logic                         result_valid,
   output logic [1:0]                   result_code,
   output logic                         winner,
   output logic                         turn,
   output logic                         game_over,
   output logic [7:0]                   move_count,
   output logic [BOARD_N*BOARD_N-1:0]   board_black,
   output logic [BOARD_N*BOARD_N-1:0]   board_white
);

   localparam int CELLS = BOARD_N * BOARD_N;
`ifdef GOBANG_EXACT_FIVE_EN
   localparam int MAXSTEP = WIN_LEN;
`else
   localparam int MAXSTEP = WIN_LEN - 1;
`endif

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CHECK  = 2'd1;
   localparam logic [1:0] S_SCAN   = 2'd2;
   localparam logic [1:0] S_RESULT = 2'd3;

   localparam logic [CELLS-1:0] ONE_HOT0 = CELLS'(1);
   localparam logic [4:0]        N5       = 5'(BOARD_N);
   localparam logic [8:0]        N9       = 9'(BOARD_N);
   localparam logic signed [5:0] N6       = 6'(BOARD_N);
   localparam logic [8:0]        CELLS9   = 9'(CELLS);
   localparam logic [3:0]        MAXK     = 4'(MAXSTEP);
   localparam logic [4:0]        WIN5     = 5'(WIN_LEN);

   logic [1:0]       state_q, state_d;
   logic [3:0]       row_q, row_d;
   logic [3:0]       col_q, col_d;
   logic [1:0]       dir_q, dir_d;
   logic             side_q, side_d;
   logic [3:0]       k_q, k_d;
   logic [4:0]       run_q, run_d;
   logic             win_q, win_d;
   logic             rej_q, rej_d;
   logic             result_valid_q, result_valid_d;
   logic [1:0]       result_code_q, result_code_d;
   logic             winner_q, winner_d;
   logic             turn_q, turn_d;
   logic             over_q, over_d;
   logic [8:0]       count_q, count_d;
   logic [CELLS-1:0] black_q, black_d;
   logic [CELLS-1:0] white_q, white_d;

   // Scan cell address: origin plus k times the direction offset, negated on the backward side
   logic signed [5:0] k_s, off_r, off_c, cell_r, cell_c;
   logic              cell_inb;
   logic [8:0]        scan_idx;
   logic [CELLS-1:0]  scan_mask;
   logic [CELLS-1:0]  mine;
   logic              hit;
   logic [4:0]        run_inc;
   logic              side_done;
   logic              dir_win;

   always_comb begin
      k_s   = $signed({2'b00, k_q});
      off_r = 6'sd0;
      off_c = 6'sd0;
      case (dir_q)
         2'd0:    off_c = k_s;
         2'd1:    off_r = k_s;
         2'd2:    begin off_r = k_s; off_c = k_s;  end
         default: begin off_r = k_s; off_c = -k_s; end
      endcase
      if (side_q) begin
         off_r = -off_r;
         off_c = -off_c;
      end
      cell_r    = $signed({2'b00, row_q}) + off_r;
      cell_c    = $signed({2'b00, col_q}) + off_c;
      cell_inb  = !cell_r[5] && !cell_c[5] && (cell_r < N6) && (cell_c < N6);
      scan_idx  = {3'b000, cell_r} * N9 + {3'b000, cell_c};
      scan_mask = ONE_HOT0 << scan_idx;
      mine      = turn_q ? white_q : black_q;
      hit       = cell_inb && |(mine & scan_mask);
      run_inc   = run_q + {4'b0000, hit};
      side_done = !hit || (k_q == MAXK);
`ifdef GOBANG_EXACT_FIVE_EN
      dir_win   = (run_inc == WIN5);
`else
      dir_win   = (run_inc >= WIN5);
`endif
   end

   logic [8:0]       chk_idx;
   logic [CELLS-1:0] chk_mask;
   logic             chk_oob;
   logic             chk_occ;

   always_comb begin
      chk_idx  = {5'b00000, row_q} * N9 + {5'b00000, col_q};
      chk_mask = ONE_HOT0 << chk_idx;
      chk_oob  = ({1'b0, row_q} >= N5) || ({1'b0, col_q} >= N5);
      chk_occ  = |((black_q | white_q) & chk_mask);
   end

   assign move_ready = (state_q == S_IDLE) && !over_q;

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      col_d          = col_q;
      dir_d          = dir_q;
      side_d         = side_q;
      k_d            = k_q;
      run_d          = run_q;
      win_d          = win_q;
      rej_d          = rej_q;
      result_valid_d = 1'b0;
      result_code_d  = result_code_q;
      winner_d       = winner_q;
      turn_d         = turn_q;
      over_d         = over_q;
      count_d        = count_q;
      black_d        = black_q;
      white_d        = white_q;

      case (state_q)
         S_IDLE: begin
            if (move_valid && move_ready) begin
               row_d   = move_row;
               col_d   = move_col;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            win_d = 1'b0;
            rej_d = chk_oob || chk_occ;
            if (chk_oob || chk_occ) begin
               state_d = S_RESULT;
            end else begin
               if (turn_q) white_d = white_q | chk_mask;
               else        black_d = black_q | chk_mask;
               count_d = count_q + 9'd1;
               dir_d   = 2'd0;
               run_d   = 5'd1;
               side_d  = 1'b0;
               k_d     = 4'd1;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            run_d = run_inc;
            if (!side_done) begin
               k_d = k_q + 4'd1;
            end else if (!side_q) begin
               side_d = 1'b1;
               k_d    = 4'd1;
            end else if (dir_win) begin
               win_d   = 1'b1;
               state_d = S_RESULT;
            end else if (dir_q == 2'd3) begin
               state_d = S_RESULT;
            end else begin
               dir_d  = dir_q + 2'd1;
               run_d  = 5'd1;
               side_d = 1'b0;
               k_d    = 4'd1;
            end
         end
         default: begin
            result_valid_d = 1'b1;
            state_d        = S_IDLE;
            if (rej_q) begin
               result_code_d = 2'd3;
            end else if (win_q) begin
               result_code_d = 2'd1;
               winner_d      = turn_q;
               over_d        = 1'b1;
            end else if (count_q == CELLS9) begin
               result_code_d = 2'd2;
               over_d        = 1'b1;
            end else begin
               result_code_d = 2'd0;
               turn_d        = ~turn_q;
            end
         end
      endcase

      // new_game overrides any in-flight move, including an unfinished scan
      if (new_game) begin
         state_d        = S_IDLE;
         dir_d          = 2'd0;
         side_d         = 1'b0;
         k_d            = 4'd0;
         run_d          = 5'd0;
         win_d          = 1'b0;
         rej_d          = 1'b0;
         result_valid_d = 1'b0;
         result_code_d  = 2'd0;
         winner_d       = 1'b0;
         turn_d         = 1'b0;
         over_d         = 1'b0;
         count_d        = 9'd0;
         black_d        = '0;
         white_d        = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         row_q          <= 4'd0;
         col_q          <= 4'd0;
         dir_q          <= 2'd0;
         side_q         <= 1'b0;
         k_q            <= 4'd0;
         run_q          <= 5'd0;
         win_q          <= 1'b0;
         rej_q          <= 1'b0;
         result_valid_q <= 1'b0;
         result_code_q  <= 2'd0;
         winner_q       <= 1'b0;
         turn_q         <= 1'b0;
         over_q         <= 1'b0;
         count_q        <= 9'd0;
         black_q        <= '0;
         white_q        <= '0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         col_q          <= col_d;
         dir_q          <= dir_d;
         side_q         <= side_d;
         k_q            <= k_d;
         run_q          <= run_d;
         win_q          <= win_d;
         rej_q          <= rej_d;
         result_valid_q <= result_valid_d;
         result_code_q  <= result_code_d;
         winner_q       <= winner_d;
         turn_q         <= turn_d;
         over_q         <= over_d;
         count_q        <= count_d;
         black_q        <= black_d;
         white_q        <= white_d;
      end
   end

   assign result_valid = result_valid_q;
   assign result_code  = result_code_q;
   assign winner       = winner_q;
   assign turn         = turn_q;
   assign game_over    = over_q;
   assign move_count   = count_q[7:0];
   assign board_black  = black_q;
   assign board_white  = white_q;

endmodule

// File: tb/tb_gobang_move_sequencer.sv
// Scoreboard bench for gobang_move_sequencer: directed moves push expected results,
// a monitor pops and compares on every result_valid pulse.
module tb_gobang_move_sequencer;

   localparam int N     = 15;
   localparam int CELLS = N * N;
`ifdef GOBANG_EXACT_FIVE_EN
   localparam int MAXSTEP = 5;
   localparam bit EXACT   = 1'b1;
`else
   localparam int MAXSTEP = 4;
   localparam bit EXACT   = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             new_game = 1'b0;
   logic             move_valid = 1'b0;
   logic [3:0]       move_row = 4'd0;
   logic [3:0]       move_col = 4'd0;
   logic             move_ready;
   logic             result_valid;
   logic [1:0]       result_code;
   logic             winner;
   logic             turn;
   logic             game_over;
   logic [7:0]       move_count;
   logic [CELLS-1:0] board_black;
   logic [CELLS-1:0] board_white;

   gobang_move_sequencer #(.BOARD_N(N), .WIN_LEN(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .new_game     (new_game),
      .move_valid   (move_valid),
      .move_ready   (move_ready),
      .move_row     (move_row),
      .move_col     (move_col),
      .result_valid (result_valid),
      .result_code  (result_code),
      .winner       (winner),
      .turn         (turn),
      .game_over    (game_over),
      .move_count   (move_count),
      .board_black  (board_black),
      .board_white  (board_white)
   );

   always #5 clk = ~clk;

   typedef struct {
      int code;
      int turn;
      int over;
      int winner;
      int count;
      int lat;
      int issue;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulses = 0;

   int               m_turn, m_over, m_winner, m_count;
   logic [CELLS-1:0] m_black, m_white;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic chk_board(input string nm, input logic [CELLS-1:0] act, input logic [CELLS-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: one expected entry per result pulse
   always @(negedge clk) begin : monitor
      exp_t e;
      int   lat;
      if (rst_n && result_valid) begin
         pulses++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got code %0d expected no pulse", result_code);
         end else begin
            e   = exp_q.pop_front();
            lat = cyc - e.issue;
            chk("result_code", int'(result_code), e.code);
            chk("turn", int'(turn), e.turn);
            chk("game_over", int'(game_over), e.over);
            chk("move_count", int'(move_count), e.count);
            if (e.code == 1) chk("winner", int'(winner), e.winner);
            if (e.lat > 0) chk("latency", lat, e.lat);
            else           chk("latency_bound", int'(lat <= 3 + 8 * MAXSTEP), 1);
         end
      end
   end

   task automatic model_clear();
      m_turn = 0; m_over = 0; m_winner = 0; m_count = 0;
      m_black = '0; m_white = '0;
   endtask

   task automatic play(input int r, input int c, input int code, input int lat);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (!move_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!move_ready) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: move_ready=0 expected 1");
         return;
      end
      if (code != 3) begin
         if (m_turn == 0) m_black[r*N+c] = 1'b1;
         else             m_white[r*N+c] = 1'b1;
         m_count++;
      end
      if (code == 1) begin m_winner = m_turn; m_over = 1; end
      if (code == 2) m_over = 1;
      if (code == 0) m_turn = 1 - m_turn;
      e.code = code; e.turn = m_turn; e.over = m_over; e.winner = m_winner;
      e.count = m_count; e.lat = lat; e.issue = cyc;
      exp_q.push_back(e);
      move_row   = 4'(r);
      move_col   = 4'(c);
      move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL result_timeout: pending=%0d expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      chk_board({tag, "_black"}, board_black, m_black);
      chk_board({tag, "_white"}, board_white, m_white);
      chk({tag, "_turn"}, int'(turn), m_turn);
      chk({tag, "_count"}, int'(move_count), m_count);
      chk({tag, "_over"}, int'(game_over), m_over);
   endtask

   task automatic do_new_game();
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      model_clear();
   endtask

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin : stim
      int p0;
      int bl_r[$], bl_c[$], wh_r[$], wh_c[$];
      model_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_state("reset");
      chk("reset_ready", int'(move_ready), 1);
      chk("reset_result_valid", int'(result_valid), 0);
      chk("reset_winner", int'(winner), 0);

      // first move, empty neighbourhood: 8 scan cycles
      play(7, 7, 0, 11);
      wait_done();
      chk("bit112", int'(board_black[112]), 1);
      check_state("first");

      // occupied and out-of-range requests
      play(7, 7, 3, 3);
      play(15, 3, 3, 3);
      wait_done();
      check_state("reject");

      // anti-diagonal five ending at (0,4)
      do_new_game();
      check_state("ng1");
      play(4, 0, 0, 0);   play(10, 10, 0, 0);
      play(3, 1, 0, 0);   play(10, 12, 0, 0);
      play(2, 2, 0, 0);   play(12, 10, 0, 0);
      play(1, 3, 0, 0);   play(12, 12, 0, 0);
      play(0, 4, 1, EXACT ? 15 : 14);
      wait_done();
      check_state("diag");
      chk("diag_ready", int'(move_ready), 0);
      p0 = pulses;
      move_row = 4'd9; move_col = 4'd9; move_valid = 1'b1;
      repeat (8) @(negedge clk);
      move_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("no_pulse_after_over", pulses - p0, 0);
      check_state("diag_hold");

      // gap fill joins forward and backward runs
      do_new_game();
      play(7, 2, 0, 0);   play(0, 0, 0, 0);
      play(7, 3, 0, 0);   play(0, 2, 0, 0);
      play(7, 5, 0, 0);   play(0, 4, 0, 0);
      play(7, 6, 0, 0);   play(0, 6, 0, 0);
      play(7, 4, 1, 9);
      wait_done();
      check_state("gap");

      // six in a row
      do_new_game();
      play(7, 0, 0, 0);   play(0, 0, 0, 0);
      play(7, 1, 0, 0);   play(0, 2, 0, 0);
      play(7, 3, 0, 0);   play(0, 4, 0, 0);
      play(7, 4, 0, 0);   play(0, 6, 0, 0);
      play(7, 5, 0, 0);   play(0, 8, 0, 0);
      play(7, 2, EXACT ? 0 : 1, EXACT ? 16 : 10);
      wait_done();
      check_state("six");

      // new_game during SCAN aborts without a result
      do_new_game();
      p0 = pulses;
      @(negedge clk);
      move_row = 4'd7; move_col = 4'd7; move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_no_pulse", pulses - p0, 0);
      check_state("abort");
      chk("abort_ready", int'(move_ready), 1);

      // full board without any five: colour by ((c/2)+r) parity, runs never exceed 2
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if ((((c / 2) + r) % 2) == 0) begin bl_r.push_back(r); bl_c.push_back(c); end
            else                          begin wh_r.push_back(r); wh_c.push_back(c); end
         end
      end
      for (int i = 0; i < bl_r.size(); i++) begin
         play(bl_r[i], bl_c[i], (i == bl_r.size() - 1) ? 2 : 0, 0);
         if (i < wh_r.size()) play(wh_r[i], wh_c[i], 0, 0);
      end
      wait_done();
      check_state("draw");
      chk("draw_ready", int'(move_ready), 0);

      do_new_game();
      @(negedge clk);
      check_state("ng_final");
      chk("ng_final_ready", int'(move_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
